// File: rtl/bcd_ascii_tx.sv
// Streams a four-digit BCD result to a byte-wide UART transmitter as ASCII,
// with optional leading-zero suppression and optional CR/LF terminator.
module bcd_ascii_tx #(
  parameter int LZ_SUPPRESS = 1,
  parameter int TERM_CRLF   = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        valid,
  input  logic [15:0] bcd,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        drop
);

  typedef enum logic [2:0] {IDLE, SCAN, SEND, WAIT_ACK, WAIT_DONE} state_t;

  localparam logic [2:0] TERM_LEN = (TERM_CRLF != 0) ? 3'd2 : 3'd0;

  state_t      state_q, state_d;
  logic [15:0] frame_q, frame_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  ndig_q, ndig_d;
  logic [2:0]  scan_ndig;
  logic [2:0]  next_idx;
  logic        more;
  logic        tx_start_d, busy_d, drop_d;
  logic [7:0]  tx_data_d;

  function automatic logic [7:0] to_ascii(input logic [3:0] nib);
    return (nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : 8'h3F;
  endfunction

  // Character k of a frame whose digit part is ndig digits long.
  function automatic logic [7:0] char_at(input logic [2:0] k, input logic [2:0] ndig,
                                         input logic [15:0] f);
    logic [1:0] pos;
    logic [3:0] nib;
    pos = 2'(ndig - k - 3'd1);
    case (pos)
      2'd0:    nib = f[3:0];
      2'd1:    nib = f[7:4];
      2'd2:    nib = f[11:8];
      default: nib = f[15:12];
    endcase
    if (k < ndig)       return to_ascii(nib);
    else if (k == ndig) return 8'h0D;
    else                return 8'h0A;
  endfunction

  always_comb begin
    scan_ndig = 3'd4;
    if (LZ_SUPPRESS != 0) begin
      if (frame_q[15:12] != 4'h0)     scan_ndig = 3'd4;
      else if (frame_q[11:8] != 4'h0) scan_ndig = 3'd3;
      else if (frame_q[7:4] != 4'h0)  scan_ndig = 3'd2;
      else                            scan_ndig = 3'd1;
    end
  end

  assign next_idx = idx_q + 3'd1;
  assign more     = next_idx < (ndig_q + TERM_LEN);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    idx_d      = idx_q;
    ndig_d     = ndig_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    drop_d     = valid && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          frame_d = bcd;
          state_d = SCAN;
        end
      end
      SCAN: begin
        ndig_d  = scan_ndig;
        idx_d   = 3'd0;
        state_d = SEND;
        // Issue the first byte straight away so it appears two cycles after valid.
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = char_at(3'd0, scan_ndig, frame_q);
        end
      end
      SEND: begin
        if (tx_start) begin
          state_d = WAIT_ACK;
        end else if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = char_at(idx_q, ndig_q, frame_q);
        end
      end
      WAIT_ACK: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (more) begin
            state_d    = SEND;
            idx_d      = next_idx;
            tx_start_d = 1'b1;
            tx_data_d  = char_at(next_idx, ndig_q, frame_q);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      frame_q  <= 16'h0000;
      idx_q    <= 3'd0;
      ndig_q   <= 3'd0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      idx_q    <= idx_d;
      ndig_q   <= ndig_d;
      tx_start <= tx_start_d;
      tx_data  <= tx_data_d;
      busy     <= busy_d;
      drop     <= drop_d;
    end
  end

endmodule

// File: doc/bcd_ascii_tx.md
BCD_ASCII_TX -- requirements
Module: bcd_ascii_tx

Interface
REQ-001 Parameter LZ_SUPPRESS, default 1: when 1, leading zero digits are not transmitted.
REQ-002 Parameter TERM_CRLF, default 1: when 1, each frame ends with CR (0x0D) then LF (0x0A).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 valid  input  1  one-cycle pulse: bcd holds a new result from the binary-to-BCD converter.
REQ-006 bcd  input  16  four BCD digits, d3=bcd[15:12] (most significant) to d0=bcd[3:0].
REQ-007 tx_busy  input  1  UART transmitter busy, high from the cycle after accepting a byte until that byte has been sent.
REQ-008 tx_start  output  1  one-cycle request to the UART transmitter to send tx_data.
REQ-009 tx_data  output  8  ASCII byte, valid while tx_start is high.
REQ-010 busy  output  1  high while a frame is in progress (state other than IDLE).
REQ-011 drop  output  1  one-cycle pulse: a valid arrived while busy and was discarded.

Function
REQ-012 States: IDLE, SCAN, SEND, WAIT_ACK, WAIT_DONE; all outputs are registered.
REQ-013 IDLE: when valid=1, latch bcd into a 16-bit frame register and go to SCAN; otherwise stay in IDLE.
REQ-014 SCAN (exactly one cycle), with LZ_SUPPRESS=1: the first digit index is the most significant nonzero digit, or d0 if all digits are zero.
REQ-015 SCAN with LZ_SUPPRESS=0: the first digit index is always d3.
REQ-016 Digit-to-character mapping: nibble 0..9 maps to 0x30+nibble; nibble 0xA..0xF maps to 0x3F ('?').
REQ-017 Character order: digits from the first index down to d0, then 0x0D and 0x0A if TERM_CRLF=1.
REQ-018 Frame length: digit count plus 0 or 2 terminator bytes; the maximum is 6 bytes.
REQ-019 SEND, tx_busy=0: assert tx_start for exactly one cycle with tx_data = current character, then go to WAIT_ACK.
REQ-020 SEND, tx_busy=1: hold in SEND without asserting tx_start.
REQ-021 WAIT_ACK: stay until tx_busy=1, then go to WAIT_DONE.
REQ-022 WAIT_ACK has no timeout; a transmitter that never raises tx_busy stalls the block until reset.
REQ-023 WAIT_DONE: stay until tx_busy=0.
REQ-024 On leaving WAIT_DONE: if more characters remain, go to SEND with the next character; otherwise go to IDLE.
REQ-025 Latency: valid high in cycle C0 gives the first tx_start in cycle C2 if tx_busy=0 in C1.
REQ-026 tx_data holds the last sent character between requests and is 0x00 after reset.
REQ-027 valid while busy=1, including the last WAIT_DONE cycle: assert drop in the next cycle, leave the frame register and state unchanged.
REQ-028 valid in IDLE is always accepted; the first IDLE cycle after a frame is the earliest acceptance point.
REQ-029 tx_start is never asserted in two consecutive cycles.
REQ-030 tx_start is never asserted while tx_busy=1 in the same cycle.
REQ-031 The frame register is not altered mid-frame, so changes on bcd during a frame have no effect.

Reset
REQ-032 nrst=0 asynchronously forces state IDLE, tx_start=0, tx_data=0x00, busy=0, drop=0, frame register 0, character index 0.
REQ-033 Reset mid-frame abandons the frame with no further tx_start.
REQ-034 After nrst rises, the block waits for a fresh valid; no partial frame is resumed.

Verification
REQ-035 bcd=0x4095, defaults, tx model busy for 10 cycles per byte -> bytes 0x34,0x30,0x39,0x35,0x0D,0x0A, then busy=0.
REQ-036 bcd=0x0007 -> 0x37,0x0D,0x0A; bcd=0x0000 -> 0x30,0x0D,0x0A.
REQ-037 LZ_SUPPRESS=0, TERM_CRLF=0, bcd=0x0042 -> 0x30,0x30,0x34,0x32 only.
REQ-038 Second valid with bcd=0x1234 during frame 0x0999 -> one drop pulse, output "999\r\n" only.
REQ-039 tx_busy held high 50 cycles before the first byte -> no tx_start until it falls, then the correct full frame.
REQ-040 nrst pulsed low after the 2nd byte of 0x4095 -> outputs reset immediately; next valid 0x0001 -> "1\r\n".
